// File: rtl/mipi_csi_tx_raw_packer_8b2lane_2ppc_if.sv
// Signal bundle for the 2-lane CSI RAW packer: pixel beats in, lane byte pairs out.
interface mipi_csi_tx_raw_packer_8b2lane_2ppc_if #(
    parameter int PIXEL_WIDTH = 16
);
    logic [2:0]               packet_type_i;
    logic                     pixel_valid_i;
    logic                     pixel_ready_o;
    logic [2*PIXEL_WIDTH-1:0] pixel_i;
    logic                     line_last_i;
    logic                     data_valid_o;
    logic [15:0]              data_o;
    logic                     line_done_o;

    modport master (
        output packet_type_i, pixel_valid_i, pixel_i, line_last_i,
        input  pixel_ready_o, data_valid_o, data_o, line_done_o
    );

    modport slave (
        input  packet_type_i, pixel_valid_i, pixel_i, line_last_i,
        output pixel_ready_o, data_valid_o, data_o, line_done_o
    );
endinterface

// File: rtl/mipi_csi_tx_raw_packer_8b2lane_2ppc.sv
// Packs 2 MSB-aligned pixels per clock into the CSI-2 RAW8/10/12 byte stream,
// emitting one byte per lane per clock through a small byte queue.
module mipi_csi_tx_raw_packer_8b2lane_2ppc #(
    parameter int PIXEL_WIDTH = 16,
    parameter int FIFO_BYTES  = 8
) (
    input logic clk_i,
    input logic reset_n_i,
    mipi_csi_tx_raw_packer_8b2lane_2ppc_if.slave bus
);
    localparam int CW = $clog2(FIFO_BYTES + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
    typedef enum logic [1:0] {M_RAW8, M_RAW10, M_RAW12} mode_t;

    state_t        state, state_next;
    mode_t         mode_q, mode_cur;
    logic [CW-1:0] count, count_next, pop_n, push_n;
    logic [7:0]    queue      [FIFO_BYTES];
    logic [7:0]    queue_next [FIFO_BYTES];
    logic [7:0]    ext        [FIFO_BYTES+2];
    logic [7:0]    push_bytes [3];
    logic          odd_beat;
    logic [3:0]    lsb_hold;
    logic          ready, accept, last_pop;
    logic [11:0]   hi0, hi1;
    logic          vld_p1, done_p1;
    logic [15:0]   data_p1;
    logic          unused_pixel_bits;

    function automatic mode_t decode_type(input logic [2:0] t);
        case (t)
            3'h3:    return M_RAW10;
            3'h4:    return M_RAW12;
            default: return M_RAW8;
        endcase
    endfunction

    // Every format's MSB byte is the top 8 bits of the slot; only the LSB nibbles differ.
    assign hi0               = bus.pixel_i[PIXEL_WIDTH-1 -: 12];
    assign hi1               = bus.pixel_i[2*PIXEL_WIDTH-1 -: 12];
    assign unused_pixel_bits = ^bus.pixel_i;
    assign mode_cur          = (state == IDLE) ? decode_type(bus.packet_type_i) : mode_q;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            ACTIVE:  ready = (count <= CW'(3));
            default: ready = 1'b0;
        endcase
    end

    assign bus.pixel_ready_o = ready & reset_n_i;
    assign accept            = bus.pixel_valid_i & bus.pixel_ready_o;

    always_comb begin
        push_bytes[0] = hi0[11:4];
        push_bytes[1] = hi1[11:4];
        push_bytes[2] = 8'h00;
        push_n        = '0;
        if (accept) begin
            push_n = CW'(2);
            case (mode_cur)
                M_RAW10: begin
                    if (odd_beat) begin
                        push_bytes[2] = {hi1[3:2], hi0[3:2], lsb_hold};
                        push_n        = CW'(3);
                    end else if (bus.line_last_i) begin
                        // Close a half group: missing pixels contribute zero LSBs.
                        push_bytes[2] = {4'h0, hi1[3:2], hi0[3:2]};
                        push_n        = CW'(3);
                    end
                end
                M_RAW12: begin
                    push_bytes[2] = {hi1[3:0], hi0[3:0]};
                    push_n        = CW'(3);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pop_n = '0;
        if (count >= CW'(2))
            pop_n = CW'(2);
        else if (state == FLUSH && count == CW'(1))
            pop_n = CW'(1);
    end

    assign last_pop   = (state == FLUSH) && (pop_n != '0) && (count == pop_n);
    assign count_next = count - pop_n + push_n;

    always_comb begin
        for (int i = 0; i < FIFO_BYTES; i++)
            ext[i] = queue[i];
        ext[FIFO_BYTES]   = 8'h00;
        ext[FIFO_BYTES+1] = 8'h00;
        for (int i = 0; i < FIFO_BYTES; i++) begin
            case (pop_n)
                CW'(1):  queue_next[i] = ext[i+1];
                CW'(2):  queue_next[i] = ext[i+2];
                default: queue_next[i] = ext[i];
            endcase
            for (int j = 0; j < 3; j++)
                if (j < int'(push_n) && i == int'(count - pop_n) + j)
                    queue_next[i] = push_bytes[j];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bus.line_last_i ? FLUSH : ACTIVE;
            ACTIVE:  if (accept && bus.line_last_i) state_next = FLUSH;
            FLUSH:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            mode_q   <= M_RAW8;
            count    <= '0;
            odd_beat <= 1'b0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            data_p1  <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            vld_p1  <= (pop_n != '0);
            done_p1 <= last_pop;
            if (pop_n != '0)
                data_p1 <= {(pop_n == CW'(2)) ? queue[1] : 8'h00, queue[0]};
            if (accept) begin
                if (state == IDLE)
                    mode_q <= mode_cur;
                odd_beat <= (mode_cur == M_RAW10) && !odd_beat && !bus.line_last_i;
            end
        end
    end

    // Byte storage carries no reset: count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_BYTES; i++)
            queue[i] <= queue_next[i];
        if (accept)
            lsb_hold <= {hi1[3:2], hi0[3:2]};
    end

    assign bus.data_valid_o = vld_p1;
    assign bus.data_o       = data_p1;
    assign bus.line_done_o  = done_p1;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count <= CW'(FIFO_BYTES));

endmodule

// File: tb/tb_mipi_csi_tx_raw_packer_8b2lane_2ppc.sv
// Directed bench for the 2-lane CSI RAW packer: hand-computed words plus a byte-list reference.
module tb_mipi_csi_tx_raw_packer_8b2lane_2ppc;
    localparam int PW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mipi_csi_tx_raw_packer_8b2lane_2ppc_if #(.PIXEL_WIDTH(PW)) bus ();

    mipi_csi_tx_raw_packer_8b2lane_2ppc #(.PIXEL_WIDTH(PW), .FIFO_BYTES(8)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          gaps = 0;
    int          lines_expected = 0;
    bit          in_line = 1'b0;
    logic [16:0] obs_q [$];
    logic [16:0] exp_q [$];
    logic [11:0] pv [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records {line_done, data} per valid word, counts bubbles inside a line.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_line = 1'b0;
        end else if (bus.data_valid_o) begin
            obs_q.push_back({bus.line_done_o, bus.data_o});
            in_line = !bus.line_done_o;
            if (bus.line_done_o) done_cnt++;
        end else begin
            if (in_line) gaps++;
            if (bus.line_done_o) done_cnt++;
        end
    end

    function automatic logic [15:0] slot(input logic [11:0] v, input int bits);
        return 16'(v) << (16 - bits);
    endfunction

    function automatic logic [16:0] obs_at(input int idx);
        if (idx < obs_q.size()) return obs_q[idx];
        return 17'h1FFFF;
    endfunction

    task automatic build_expected(input int mode, input int n);
        logic [7:0] b [$];
        logic [7:0] l;
        exp_q.delete();
        if (mode == 10) begin
            for (int g = 0; g < n; g += 4) begin
                l = 8'h00;
                for (int k = 0; k < 4; k++)
                    if (g + k < n) begin
                        b.push_back(pv[g+k][9:2]);
                        l = l | (8'(pv[g+k][1:0]) << (2 * k));
                    end
                b.push_back(l);
            end
        end else if (mode == 12) begin
            for (int i = 0; i < n; i += 2) begin
                b.push_back(pv[i][11:4]);
                b.push_back(pv[i+1][11:4]);
                b.push_back({pv[i+1][3:0], pv[i][3:0]});
            end
        end else begin
            for (int i = 0; i < n; i++) b.push_back(pv[i][7:0]);
        end
        for (int i = 0; i < b.size(); i += 2)
            exp_q.push_back({(i + 2 >= b.size()) ? 1'b1 : 1'b0,
                             (i + 1 < b.size()) ? b[i+1] : 8'h00, b[i]});
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [2:0] t, input logic [15:0] p0, input logic [15:0] p1,
                             input logic last, output int nstall);
        int budget;
        bus.packet_type_i = t;
        bus.pixel_i       = {p1, p0};
        bus.line_last_i   = last;
        bus.pixel_valid_i = 1'b1;
        nstall = 0;
        budget = 0;
        @(negedge clk);
        while (!bus.pixel_ready_o && budget < 50) begin
            nstall++;
            budget++;
            @(negedge clk);
        end
        if (!bus.pixel_ready_o) check("ready_timeout", bus.pixel_ready_o, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_line_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("line_done_count", done_cnt, target);
    endtask

    task automatic run_line(input logic [2:0] t_first, input logic [2:0] t_rest, input int mode,
                            input int idle, output int stalls, output int base);
        int s;
        int n;
        n = pv.size();
        build_expected(mode, n);
        base   = obs_q.size();
        stalls = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i += 2) begin
            send_beat((i == 0) ? t_first : t_rest, slot(pv[i], mode), slot(pv[i+1], mode),
                      (i + 2 >= n), s);
            stalls += s;
            if (idle > 0) begin
                bus.pixel_valid_i = 1'b0;
                repeat (idle) @(posedge clk);
                #1;
            end
        end
        bus.pixel_valid_i = 1'b0;
        bus.line_last_i   = 1'b0;
        lines_expected++;
        wait_line_done(lines_expected);
        repeat (3) @(negedge clk);
        check("word_count", obs_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            check("ref_word", obs_at(base + k), exp_q[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, base, g0, s;
        bus.packet_type_i = 3'h2;
        bus.pixel_valid_i = 1'b0;
        bus.pixel_i       = '0;
        bus.line_last_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.data_valid_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_done", bus.line_done_o, 0);
        check("rst_ready", bus.pixel_ready_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.pixel_ready_o, 1);

        // RAW10 single group
        pv = '{12'h2A5, 12'h0C3, 12'h3FF, 12'h000};
        run_line(3'h3, 3'h3, 10, 0, stalls, base);
        check("raw10_w0", obs_at(base), 17'h030A9);
        check("raw10_w1", obs_at(base + 1), 17'h000FF);
        check("raw10_w2", obs_at(base + 2), 17'h1003D);

        // RAW12 single beat
        pv = '{12'hABC, 12'h123};
        run_line(3'h4, 3'h4, 12, 0, stalls, base);
        check("raw12_w0", obs_at(base), 17'h012AB);
        check("raw12_w1", obs_at(base + 1), 17'h1003C);

        // RAW12 with packet type changed on the second beat: line keeps RAW12
        pv = '{12'hFED, 12'h0F1, 12'h800, 12'h07F};
        run_line(3'h4, 3'h2, 12, 0, stalls, base);
        check("latch_w0", obs_at(base), 17'h00FFE);
        check("latch_w1", obs_at(base + 1), 17'h0801D);
        check("latch_w2", obs_at(base + 2), 17'h1F007);

        // RAW8 640 pixels, valid held
        pv.delete();
        for (int i = 0; i < 640; i++) pv.push_back(12'((i * 7 + 3) & 8'hFF));
        g0 = gaps;
        run_line(3'h2, 3'h2, 8, 0, stalls, base);
        check("raw8_stalls", stalls, 0);
        check("raw8_gaps", gaps - g0, 0);
        check("raw8_words", obs_q.size() - base, 320);

        // RAW10 1280 pixels, valid held: one stall after every fourth beat
        pv.delete();
        for (int i = 0; i < 1280; i++) pv.push_back(12'((i * 37 + 5) & 10'h3FF));
        g0 = gaps;
        run_line(3'h3, 3'h3, 10, 0, stalls, base);
        check("raw10_stalls", stalls, 159);
        check("raw10_gaps", gaps - g0, 0);
        check("raw10_words", obs_q.size() - base, 800);
        check("raw10_last_done", obs_at(base + 799), {1'b1, exp_q[799][15:0]});

        // RAW10 odd beat count with valid pauses between beats
        pv = '{12'h001, 12'h3FE, 12'h155, 12'h2AA, 12'h37B, 12'h0C6};
        run_line(3'h3, 3'h3, 10, 2, stalls, base);
        check("odd_w0", obs_at(base), 17'h0FF00);
        check("odd_w1", obs_at(base + 1), 17'h0AA55);
        check("odd_w2", obs_at(base + 2), 17'h0DE99);
        check("odd_w3", obs_at(base + 3), 17'h10B31);

        // Unsupported type packs as RAW8
        pv = '{12'h05A, 12'h0C3};
        run_line(3'h7, 3'h7, 8, 0, stalls, base);
        check("unsup_w0", obs_at(base), 17'h1C35A);

        // Reset mid-line with bytes queued
        @(posedge clk);
        #1;
        send_beat(3'h4, slot(12'h111, 12), slot(12'h222, 12), 1'b0, s);
        send_beat(3'h4, slot(12'h333, 12), slot(12'h444, 12), 1'b0, s);
        bus.pixel_valid_i = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", bus.data_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.data_valid_o, 0);
        check("midrst_data", bus.data_o, 0);
        check("midrst_done", bus.line_done_o, 0);
        check("midrst_ready", bus.pixel_ready_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pv = '{12'h123, 12'h456, 12'h789, 12'hABC};
        run_line(3'h4, 3'h4, 12, 0, stalls, base);
        check("post_rst_w0", obs_at(base), 17'h04512);
        check("post_rst_w1", obs_at(base + 1), 17'h07863);
        check("post_rst_w2", obs_at(base + 2), 17'h1C9AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mipi_csi_tx_raw_packer_8b2lane_2ppc.md
Name: mipi_csi_tx_raw_packer_8b2lane_2ppc

Overview:
- Transmit-side RAW packer for the 2-lane, 8-bit-gear CSI path.
- Accepts 2 MSB-aligned pixels per clock from the image pipeline and packs them into the MIPI CSI-2 RAW8/RAW10/RAW12 byte stream, one byte per lane per clock.
- Sits between the pixel source and the CSI TX packet builder, which adds header/CRC and drives the lanes.
- Packing expands RAW10/RAW12 byte count, so the block throttles its input with a ready/valid handshake.

Parameters:
- PIXEL_WIDTH, 16, width of each input pixel slot; pixel value is MSB-aligned, low bits ignored.
- FIFO_BYTES, 8, capacity of the internal byte queue. Minimum 6.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous and active-low.
- packet_type_i  in  3  low 3 bits of the CSI data type: 3'h2 = RAW8 (0x2A), 3'h3 = RAW10 (0x2B), 3'h4 = RAW12 (0x2C).
- pixel_valid_i  in  1  input beat valid.
- pixel_ready_o  out  1  block can accept a beat this cycle.
- pixel_i  in  2*PIXEL_WIDTH  bits [PIXEL_WIDTH-1:0] hold pixel 0 (first on wire), the upper slot holds pixel 1.
- line_last_i  in  1  qualifies the final beat of a line.
- data_valid_o  out  1  data_o holds 2 valid wire bytes.
- data_o  out  16  [7:0] = lane 0 (earlier byte), [15:8] = lane 1.
- line_done_o  out  1  1-cycle pulse coincident with the final data_valid_o of a line.

Behaviour:
- Reset: data_valid_o=0, data_o=0, line_done_o=0, queue empty, FSM=IDLE, pixel_ready_o=0 while reset is asserted. Reset mid-line discards all queued bytes and packing state; there is no partial output.
- A beat is accepted when pixel_valid_i && pixel_ready_o.
- FSM IDLE:
  - pixel_ready_o=1.
  - The first accepted beat latches packet_type_i for the whole line and moves the FSM to ACTIVE.
  - Unsupported types pack as RAW8.
- FSM ACTIVE:
  - pixel_ready_o = (queue count <= 3), computed from registered state only.
  - Accepting a beat with line_last_i=1 moves the FSM to FLUSH.
- FSM FLUSH:
  - pixel_ready_o=0.
  - Drains the queue, then returns to IDLE.
  - The next line may be accepted the cycle after the FSM returns to IDLE.
- Bytes appended per accepted beat, in wire order. Px[N:M] denotes bits of the MSB-aligned value.
  - RAW8: p0[7:0], p1[7:0].
  - RAW10, even beat of group: p0[9:2], p1[9:2]; the 2-bit LSBs are held internally.
  - RAW10, odd beat of group: p2[9:2], p3[9:2], then the LSB byte {p3[1:0], p2[1:0], p1[1:0], p0[1:0]}.
  - RAW12, every beat: p0[11:4], p1[11:4], then {p1[3:0], p0[3:0]}.
- Output step, each cycle:
  - If queue count >= 2: pop 2 bytes into data_o (first popped byte into [7:0]) and set data_valid_o=1.
  - Otherwise data_valid_o=0 and data_o holds its value.
  - Pop and push in the same cycle are legal; count_next = count - pop + push.
- Latency: bytes of a beat accepted at cycle N appear on data_o at N+1 at the earliest.
- Throughput: input is throttled to the following long-run beat rates, with no output bubbles while input is supplied.
  - RAW8: 1 beat per cycle.
  - RAW10: 4 beats per 5 cycles.
  - RAW12: 2 beats per 3 cycles.
- End of line, RAW10 with an odd beat count: the group is closed by emitting an LSB byte with p2/p3 LSBs = 0. No p2/p3 MSB bytes are emitted.
- FLUSH with 1 byte left: emit data_o = {8'h00, byte} with data_valid_o=1.
- line_done_o pulses with the last data_valid_o of a line. If the line produced no bytes, it cannot occur.
- Overflow is impossible by construction. An assertion checks count <= FIFO_BYTES.
- pixel_valid_i deasserted mid-line is legal: output pauses once the queue holds fewer than 2 bytes.

Test Plan:
- RAW10, one group: beat0 = {0x0C3<<6, 0x2A5<<6}, beat1 = {0x000<<6, 0x3FF<<6} with line_last_i.
  - Required data_o sequence 0x30A9, 0x00FF, 0x003D.
  - line_done_o on the third word.
- RAW12, one beat {0x123<<4, 0xABC<<4} with line_last_i -> 0x12AB, then 0x003C with line_done_o.
- RAW8, 640-pixel line with pixel_valid_i held high:
  - pixel_ready_o never drops.
  - 320 consecutive data_valid_o with data_o = {p1[7:0], p0[7:0]}.
- RAW10, 1280 pixels with valid held high:
  - pixel_ready_o pattern settles to 4 of every 5 cycles.
  - Exactly 800 output words with no valid gaps.
  - Last word carries line_done_o.
- RAW10, odd beat count (6 pixels) -> bytes p0..p3 MSBs, LSB byte, p4, p5 MSBs, padded LSB byte {0,0,p5l,p4l} = 8 bytes = 4 words.
- Assert reset_n_i mid-line with queue non-empty:
  - Outputs go to 0 immediately.
  - The following RAW12 line packs correctly from its first byte.
